// File: rtl/if_fetch_unit.sv
// IF-stage producer: owns the PC, fetches over a req/ack instruction-memory port and
// feeds pc+4 / instruction into IF/ID, honouring hazard stalls and jump/branch redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req stays high with imem_addr stable until the cycle imem_ack is
  // high; that cycle completes the transfer, and at most one request is ever in flight.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt_pc;
  logic [31:0] inst_buf;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;
  logic        req_state;
  logic        valid_int;

  assign pc_plus4         = pc + 32'd4;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign req_state        = (state == S_REQ) || (state == S_DRAIN);
  assign valid_int        = ((state == S_REQ) && imem_ack) || (state == S_HOLD);

  // Outputs are gated by reset so the memory sees the request drop immediately.
  always_comb begin
    imem_req       = 1'b0;
    imem_addr      = 32'h0;
    if_valid       = 1'b0;
    if_instruction = 32'h0;
    if_pc_plus4    = 32'h0;
    if (!reset) begin
      imem_req  = req_state;
      imem_addr = req_state ? pc : 32'h0;
      if_valid  = valid_int;
      if (valid_int) begin
        if_instruction = (state == S_HOLD) ? inst_buf : imem_rdata;
        if_pc_plus4    = pc_plus4;
      end
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      tgt_pc   <= RESET_PC;
      inst_buf <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              pc <= redirect_aligned;
            end else if (!stall) begin
              pc <= pc_plus4;
            end else begin
              inst_buf <= imem_rdata;
              state    <= S_HOLD;
            end
          end else if (redirect) begin
            // The request cannot be withdrawn; park the target until the ack drains it.
            tgt_pc <= redirect_aligned;
            state  <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= redirect_aligned;
            state <= S_REQ;
          end else if (!stall) begin
            pc    <= pc_plus4;
            state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (redirect) tgt_pc <= redirect_aligned;
          if (imem_ack) begin
            pc    <= redirect ? redirect_aligned : tgt_pc;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: hand-computed vectors for streaming, wait states,
// stall hold, redirect drain, redirect priority, PC wrap and asynchronous reset.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc_plus4(if_pc_plus4),
    .if_instruction(if_instruction), .if_valid(if_valid), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Set inputs for the current cycle (called #1 after a posedge).
  task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl,
                       input logic redir, input logic [31:0] rpc);
    imem_ack    = ack;
    imem_rdata  = rdata;
    stall       = stl;
    redirect    = redir;
    redirect_pc = rpc;
    #2;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] inst, input logic [31:0] p4);
    check({tag, ".req"},   {31'h0, imem_req}, {31'h0, req});
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".valid"}, {31'h0, if_valid}, {31'h0, vld});
    check({tag, ".inst"},  if_instruction, inst);
    check({tag, ".p4"},    if_pc_plus4, p4);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0);
    expect_out("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    do_reset();

    // 1: zero-wait streaming
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1000_0000 + k, 1'b0, 1'b0, 32'h0);
      expect_out($sformatf("t1_%0d", k), 1'b1, 32'(4 * k), 1'b1, 32'h1000_0000 + k, 32'(4 * k + 4));
      step();
    end

    // 2: ack latency 3 at address 0
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
      expect_out($sformatf("t2_wait%0d", k), 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      step();
    end
    drive(1'b1, 32'h2000_0000, 1'b0, 1'b0, 32'h0);
    expect_out("t2_ack", 1'b1, 32'h0, 1'b1, 32'h2000_0000, 32'h4);
    step();
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 32'h2000_0000 + k, 1'b0, 1'b0, 32'h0);
      check($sformatf("t2_addr%0d", k), imem_addr, 32'(4 * k));
      step();
    end

    // 3: ack at 0x10 with stall -> S_HOLD
    drive(1'b1, 32'hDEAD_0010, 1'b1, 1'b0, 32'h0);
    expect_out("t3_ack", 1'b1, 32'h10, 1'b1, 32'hDEAD_0010, 32'h14);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_out("t3_hold", 1'b0, 32'h0, 1'b1, 32'hDEAD_0010, 32'h14);
    check("t3_state", {30'h0, dbg_state}, 32'd1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("t3_release", 1'b0, 32'h0, 1'b1, 32'hDEAD_0010, 32'h14);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("t3_next", 1'b1, 32'h14, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h3000_0000, 1'b0, 1'b0, 32'h0);
      check($sformatf("t3_addr%0d", k), imem_addr, 32'h14 + 32'(4 * k));
      step();
    end

    // 4: redirect while a request is pending at 0x20
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h103);
    expect_out("t4_redir", 1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("t4_drain", 1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    check("t4_state", {30'h0, dbg_state}, 32'd2);
    step();
    drive(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0);
    expect_out("t4_drop", 1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("t4_target", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);

    // 5: redirect and stall together in S_HOLD
    drive(1'b1, 32'h4000_0100, 1'b1, 1'b0, 32'h0);
    check("t5_ack_valid", {31'h0, if_valid}, 32'h1);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    expect_out("t5_hold", 1'b0, 32'h0, 1'b1, 32'h4000_0100, 32'h104);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_out("t5_target", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);

    // latest redirect wins while draining, including one coincident with the ack
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h400);
    step();
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h502);
    check("t5_drain_valid", {31'h0, if_valid}, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("t5_latest", imem_addr, 32'h500);

    // 6: wrap at the top of the address space
    drive(1'b1, 32'h6000_0500, 1'b0, 1'b1, 32'hFFFF_FFFC);
    expect_out("t6_redir", 1'b1, 32'h500, 1'b1, 32'h6000_0500, 32'h504);
    step();
    drive(1'b1, 32'h6000_FFFC, 1'b0, 1'b0, 32'h0);
    expect_out("t6_wrap", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h6000_FFFC, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("t6_zero", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();

    // asynchronous reset in the middle of a wait, with an ack arriving alongside
    #2;
    reset = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_7777;
    #1;
    expect_out("t6_async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("t6_after_rst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
